// File: rtl/d_ff_pkg.sv
// d_ff_pkg: shared defaults and parameter-legality helper for d_ff.
// Holds D_FF_DEF_WIDTH, D_FF_DEF_STAGES and d_ff_params_ok().
package d_ff_pkg;

    localparam int D_FF_DEF_WIDTH  = 1;
    localparam int D_FF_DEF_STAGES = 1;

    // True when the register geometry is buildable.
    function automatic bit d_ff_params_ok(
        input int width,
        input int stages
    );
        return (width >= 1) && (stages >= 1);
    endfunction

endpackage

// File: rtl/d_ff_stage.sv
// d_ff_stage: one WIDTH-bit register, async active-high reset to RST_VAL.
// Ports: clk (rising edge), rst (async, active-high), d (in), q (out).
module d_ff_stage
    import d_ff_pkg::*;
#(
    parameter int               WIDTH   = D_FF_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/d_ff.sv
// d_ff: STAGES-deep chain of WIDTH-bit registers, async active-high reset.
// Ports: clk (rising edge), rst (async, active-high), d (in), q (last stage).
// Macro D_FF_ASSERT_EN: compiles in simulation-only input/parameter checks.
module d_ff
    import d_ff_pkg::*;
#(
    parameter int               WIDTH   = D_FF_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               STAGES  = D_FF_DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // chain[0] is the input, chain[k+1] is the output of stage k.
    logic [WIDTH-1:0] chain [STAGES+1];

    assign chain[0] = d;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        d_ff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d   (chain[i]),
            .q   (chain[i+1])
        );
    end

    assign q = chain[STAGES];

`ifdef D_FF_ASSERT_EN
    if (!d_ff_params_ok(WIDTH, STAGES)) begin : g_bad_params
        $fatal(1, "d_ff: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    always @(posedge clk) begin
        if (rst === 1'b0 && $isunknown(d)) begin
            $error("d_ff: X/Z on d at clock edge");
        end
    end

    always @(rst) begin
        if ($time > 0 && $isunknown(rst)) begin
            $error("d_ff: X/Z on rst");
        end
    end
`endif

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: directed vector bench for d_ff (default 1-bit/1-stage and
// an 8-bit/3-stage/A5 pipeline sharing clk and rst).
`timescale 1ps/1ps
module tb_d_ff;

    logic       clk;
    logic       rst;
    logic       d1;
    logic       q1;
    logic [7:0] d8;
    logic [7:0] q8;

    int n_checks   = 0;
    int miscompares = 0;

    d_ff u_dut1 (
        .clk (clk),
        .rst (rst),
        .d   (d1),
        .q   (q1)
    );

    d_ff #(
        .WIDTH   (8),
        .RST_VAL (8'hA5),
        .STAGES  (3)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .d   (d8),
        .q   (q8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       d1;
        logic       q1;
        logic [7:0] d8;
        logic [7:0] q8;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    initial begin
        // rst, d1, q1, d8, q8 (q checked 1 ps after the edge)
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'hA5};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h01, 8'hA5};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h02, 8'hA5};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h03, 8'h01};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h02};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h05, 8'h03};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h06, 8'hA5};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h07, 8'hA5};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h08, 8'hA5};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h09, 8'h07};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h0A, 8'h08};

        // Power-up reset.
        rst = 1'b1;
        d1  = 1'b0;
        d8  = 8'h00;
        #1;
        check("por_q1", {7'b0, q1}, 8'h00);
        check("por_q8", q8, 8'hA5);
        rst = 1'b0;
        #3;
        check("por_hold_q1", {7'b0, q1}, 8'h00);

        // Table: inputs driven on the falling edge.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            d1  = vecs[i].d1;
            d8  = vecs[i].d8;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_q1", i), {7'b0, q1}, {7'b0, vecs[i].q1});
            check($sformatf("vec%0d_q8", i), q8, vecs[i].q8);
        end

        // Async reset pulse between edges, then refill.
        @(negedge clk);
        d1 = 1'b1;
        d8 = 8'h55;
        @(posedge clk);
        #1;
        check("pre_pulse_q1", {7'b0, q1}, 8'h01);
        check("pre_pulse_q8", q8, 8'h09);
        #2;
        rst = 1'b1;
        #1;
        check("pulse_q1", {7'b0, q1}, 8'h00);
        check("pulse_q8", q8, 8'hA5);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("refill1_q1", {7'b0, q1}, 8'h01);
        check("refill1_q8", q8, 8'hA5);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("refill3_q8", q8, 8'h55);

        // Reset held across a rising edge with d=1.
        @(negedge clk);
        #4;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ovl_q1", {7'b0, q1}, 8'h00);
        check("ovl_q8", q8, 8'hA5);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ovl_after_q1", {7'b0, q1}, 8'h01);
        check("ovl_after_q8", q8, 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_checks, miscompares);
        $finish;
    end

endmodule

// File: doc/d_ff.md
# d_ff

Parameterized positive-edge D flip-flop register with asynchronous active-high reset. It is the basic storage primitive for registering single bits or buses, and for building short retiming pipelines anywhere in the design. The default configuration is a 1-bit, single-stage register that resets to 0.

## Interface
- `WIDTH`, default 1: data width in bits; legal range ≥ 1.
- `RST_VAL`, default `'0`: value every stage takes while reset is asserted; `WIDTH` bits.
- `STAGES`, default 1: number of cascaded register stages; legal range ≥ 1.
- `clk`  input  1  clock; all state updates occur on the rising edge.
- `rst`  input  1  reset. One clock; reset is asynchronous and active-high.
- `d`  input  WIDTH  data input, sampled on the rising edge of `clk`.
- `q`  output  WIDTH  registered output from the last stage.

## Operation
- The block is a chain of `STAGES` registers.
  - Stage 0 captures `d`.
  - Stage k captures stage k-1.
  - `q` is driven by stage `STAGES-1`.
- Reset:
  - While `rst`=1, every stage is forced to `RST_VAL`, independent of `clk`.
  - Rising edges of `clk` during reset have no effect.
- Normal operation (`rst`=0): on each rising edge of `clk`, every stage loads its input at the same time.
- There is no enable and no synchronous clear. The register loads on every edge.
- `q` is a pure register output, with no combinational path from `d` or `clk`.
- Width rule: `d`, `q` and `RST_VAL` are all exactly `WIDTH` bits, with no extension or truncation inside the block.

## Timing
- Latency: `q` equals the `d` value sampled `STAGES` rising edges earlier.
  - With the default `STAGES`=1, `q` follows `d` one edge later.
- Reset assertion:
  - `q` goes to `RST_VAL` in the same simulation timestep as the `rst` rising edge.
  - It does not wait for a clock edge.
- Reset deassertion:
  - `q` holds `RST_VAL` until the first rising `clk` edge at which `rst`=0.
  - At that edge, stage 0 loads `d`.
- Reset mid-operation: an `rst` pulse shorter than one clock period between two edges still clears every stage at once. The pipeline then refills from `d`, so `q` shows live data again after `STAGES` edges.
- Simultaneous `rst` and clock edge: reset wins and `q` is `RST_VAL`.
- Before the first reset, `q` is undefined (X). Users must apply reset.

## Configuration
- Macro `D_FF_ASSERT_EN`.
- Defined: simulation-only checks are compiled in.
  - Error if `d` contains X/Z at a rising `clk` edge while `rst`=0.
  - Error if `rst` is X/Z at any time after time 0.
  - Fatal at elaboration if `WIDTH` < 1 or `STAGES` < 1.
- Undefined: no checks are compiled. The synthesized logic is identical in both cases.

## Structure
- Shared package `d_ff_pkg`: holds the default constants `D_FF_DEF_WIDTH`=1 and `D_FF_DEF_STAGES`=1, plus the parameter-legality check function used by the assertions.
- One sub-module, `d_ff_stage`:
  - a single `WIDTH`-bit register with async active-high reset to `RST_VAL`;
  - instantiated `STAGES` times by a generate loop in `d_ff`.

## Test plan
All scenarios use a 10 ps clock, with `clk` starting at 0 and rising edges at 5, 15, 25 ps and so on.
- Power-up reset, defaults: hold `rst`=1 from 0 to 1 ps, then 0 → `q`=0 at t=0. `q` stays 0 until `d` is first sampled.
- Capture:
  - `d`=0 at 8 ps, then `d`=1 at 28 ps → `q`=0 after the 15 ps edge and `q`=1 after the 35 ps edge.
  - `d`=0 at 68 ps → `q`=0 after the 75 ps edge.
- Async reset mid-operation: with `q`=1, pulse `rst`=1 from 38 to 41 ps → `q`=0 at 38 ps, with no clock edge involved. `q`=1 again after the 45 ps edge while `d`=1.
- Reset overlapping an edge: hold `rst`=1 from 14 to 16 ps with `d`=1 → `q`=0 through the 15 ps edge. `q`=1 after the 25 ps edge.
- Pipeline: set `WIDTH`=8, `STAGES`=3, `RST_VAL`=8'hA5, and drive `d`=8'h01, 8'h02, 8'h03 on consecutive edges after reset → `q`=8'hA5 until the third edge after `d`=8'h01 is applied. `q` then shows 01, 02, 03 on successive edges.
- Assertions (`D_FF_ASSERT_EN` defined): drive `d`=X at a rising edge with `rst`=0 → one error reported. The same stimulus with `rst`=1 → no error.
